mem_bus_arbiter: RTL and testbench

//  Shares the single-port system memory (RAM below ROM_BASE, ROM at/above it) between the 6502 core
//  and a DMA/test-loader port. Decides one winner per ph1 cycle and muxes its access onto the memory port.

---
 rtl/mem_bus_arbiter.sv | 173 +++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: one-winner-per-cycle arbiter between the 6502 core and a
// DMA/test-loader port in front of the single-port system memory.
// Bounds DMA starvation (MAX_WAIT) and DMA burst length (MAX_BURST), and drops
// writes at or above ROM_BASE.
// Optional grant/stall statistics are enabled with the macro MEM_ARB_STATS_EN.
module mem_bus_arbiter #(
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned DATA_W    = 8,
    parameter logic [ADDR_W-1:0] ROM_BASE = 16'hF000,
    parameter int unsigned MAX_WAIT  = 4,
    parameter int unsigned MAX_BURST = 8
) (
    input  logic              ph1,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    input  logic              dma_lock,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [DATA_W-1:0] dma_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              wp_err,
    output logic [15:0]       stat_cpu,
    output logic [15:0]       stat_dma,
    output logic [15:0]       stat_stall
);

    localparam int unsigned WAIT_W  = 4;
    localparam int unsigned BURST_W = 8;
    localparam int unsigned STAT_W  = 16;

    typedef enum logic {FREE, LOCK} state_t;

    state_t               state_q, state_d;
    logic [WAIT_W-1:0]    starve_q, starve_d;
    logic [BURST_W-1:0]   burst_q, burst_d;
    logic                 cpu_win, dma_win, any_win;
    logic                 win_we;
    logic [ADDR_W-1:0]    win_addr;
    logic [DATA_W-1:0]    win_wdata;
    logic                 win_rom;
    logic [ADDR_W-1:0]    addr_hold_q;
    logic [DATA_W-1:0]    wdata_hold_q;

    // State, starvation and burst registers
    always_ff @(posedge ph1) begin
        if (reset) begin
            state_q  <= FREE;
            starve_q <= '0;
            burst_q  <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            burst_q  <= burst_d;
        end
    end

    // Winner selection, next state, starvation/burst bookkeeping; grants gated by reset
    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        burst_d  = burst_q;
        cpu_win  = 1'b0;
        dma_win  = 1'b0;
        if (!reset) begin
            case (state_q)
                FREE: begin
                    if (dma_req && (!cpu_req || starve_q == WAIT_W'(MAX_WAIT))) begin
                        dma_win = 1'b1;
                    end else if (cpu_req) begin
                        cpu_win = 1'b1;
                    end
                    if (dma_win && dma_lock && (MAX_BURST > 1)) begin
                        state_d = LOCK;
                        burst_d = BURST_W'(1);
                    end
                end
                LOCK: begin
                    dma_win = dma_req;
                    if (!dma_req || !dma_lock) begin
                        state_d = FREE;
                        burst_d = '0;
                    end else begin
                        burst_d = burst_q + BURST_W'(1);
                        if (burst_d == BURST_W'(MAX_BURST)) begin
                            state_d = FREE;
                            burst_d = '0;
                        end
                    end
                end
                default: state_d = FREE;
            endcase
            if (!dma_req || dma_win) begin
                starve_d = '0;
            end else if (cpu_win && starve_q != WAIT_W'(MAX_WAIT)) begin
                starve_d = starve_q + WAIT_W'(1);
            end
        end
    end

    assign cpu_gnt   = cpu_win;
    assign dma_gnt   = dma_win;
    assign any_win   = cpu_win | dma_win;
    assign win_we    = dma_win ? dma_we    : cpu_we;
    assign win_addr  = dma_win ? dma_addr  : cpu_addr;
    assign win_wdata = dma_win ? dma_wdata : cpu_wdata;
    assign win_rom   = (win_addr >= ROM_BASE);

    // Memory port follows the winner; idle cycles replay the last address/data with no write
    assign mem_addr  = any_win ? win_addr  : addr_hold_q;
    assign mem_wdata = any_win ? win_wdata : wdata_hold_q;
    assign mem_we    = any_win & win_we & ~win_rom;
    assign cpu_rdata = mem_rdata;
    assign dma_rdata = mem_rdata;

    // Held bus value, read-valid and write-protect pulses
    always_ff @(posedge ph1) begin
        if (reset) begin
            addr_hold_q  <= '0;
            wdata_hold_q <= '0;
            cpu_rvalid   <= 1'b0;
            dma_rvalid   <= 1'b0;
            wp_err       <= 1'b0;
        end else begin
            addr_hold_q  <= mem_addr;
            wdata_hold_q <= mem_wdata;
            cpu_rvalid   <= cpu_win & ~cpu_we;
            dma_rvalid   <= dma_win & ~dma_we;
            wp_err       <= any_win & win_we & win_rom;
        end
    end

`ifdef MEM_ARB_STATS_EN
    logic [STAT_W-1:0] stat_cpu_q, stat_dma_q, stat_stall_q;
    logic              stall;

    assign stall = (cpu_req & ~cpu_win) | (dma_req & ~dma_win);

    // Saturating grant and stall counters
    always_ff @(posedge ph1) begin
        if (reset) begin
            stat_cpu_q   <= '0;
            stat_dma_q   <= '0;
            stat_stall_q <= '0;
        end else begin
            if (cpu_win && stat_cpu_q != '1)   stat_cpu_q   <= stat_cpu_q + STAT_W'(1);
            if (dma_win && stat_dma_q != '1)   stat_dma_q   <= stat_dma_q + STAT_W'(1);
            if (stall && stat_stall_q != '1)   stat_stall_q <= stat_stall_q + STAT_W'(1);
        end
    end

    assign stat_cpu   = stat_cpu_q;
    assign stat_dma   = stat_dma_q;
    assign stat_stall = stat_stall_q;
`else
    assign stat_cpu   = '0;
    assign stat_dma   = '0;
    assign stat_stall = '0;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter with a simple synchronous RAM model.
module tb_mem_bus_arbiter;

    logic        ph1 = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata, cpu_rdata;
    logic        dma_req, dma_we, dma_lock, dma_gnt, dma_rvalid;
    logic [15:0] dma_addr;
    logic [7:0]  dma_wdata, dma_rdata;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = 8'h00;
    logic        wp_err;
    logic [15:0] stat_cpu, stat_dma, stat_stall;

    logic [7:0]  mem [0:65535];

    int checks = 0;
    int errors = 0;

    always #5 ph1 = ~ph1;

    mem_bus_arbiter dut (
        .ph1        (ph1),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .dma_req    (dma_req),
        .dma_we     (dma_we),
        .dma_addr   (dma_addr),
        .dma_wdata  (dma_wdata),
        .dma_lock   (dma_lock),
        .dma_gnt    (dma_gnt),
        .dma_rvalid (dma_rvalid),
        .dma_rdata  (dma_rdata),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .wp_err     (wp_err),
        .stat_cpu   (stat_cpu),
        .stat_dma   (stat_dma),
        .stat_stall (stat_stall)
    );

    // Single-port synchronous memory: read data one cycle after the address
    always @(posedge ph1) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge ph1);
        #1;
    endtask

    task automatic idle_all();
        cpu_req  = 1'b0;
        cpu_we   = 1'b0;
        dma_req  = 1'b0;
        dma_we   = 1'b0;
        dma_lock = 1'b0;
    endtask

    initial begin
        logic exp_d;
        reset     = 1'b1;
        cpu_addr  = 16'h0000;
        cpu_wdata = 8'h00;
        dma_addr  = 16'h0000;
        dma_wdata = 8'h00;
        idle_all();
        mem[16'hF000] = 8'h5A;
        tick();
        tick();

        // Reset: grants gated, registered outputs clear, bus at zero
        cpu_req  = 1'b1;
        cpu_addr = 16'h0010;
        dma_req  = 1'b1;
        @(negedge ph1);
        check("rst_cpu_gnt", 32'(cpu_gnt), 32'd0);
        check("rst_dma_gnt", 32'(dma_gnt), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'h0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        tick();
        check("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
        check("rst_dma_rvalid", 32'(dma_rvalid), 32'd0);
        check("rst_wp_err", 32'(wp_err), 32'd0);
        idle_all();
        reset = 1'b0;
        tick();

        // CPU only: write 33 to 0040, then read it back
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = 16'h0040;
        cpu_wdata = 8'h33;
        @(negedge ph1);
        check("wr_cpu_gnt", 32'(cpu_gnt), 32'd1);
        check("wr_mem_we", 32'(mem_we), 32'd1);
        check("wr_mem_addr", 32'(mem_addr), 32'h0040);
        check("wr_mem_wdata", 32'(mem_wdata), 32'h33);
        tick();
        check("wr_no_rvalid", 32'(cpu_rvalid), 32'd0);
        cpu_we = 1'b0;
        @(negedge ph1);
        check("rd_cpu_gnt", 32'(cpu_gnt), 32'd1);
        check("rd_mem_we", 32'(mem_we), 32'd0);
        tick();
        cpu_req = 1'b0;
        check("rd_cpu_rvalid", 32'(cpu_rvalid), 32'd1);
        check("rd_cpu_rdata", 32'(cpu_rdata), 32'h33);
        check("rd_dma_rvalid", 32'(dma_rvalid), 32'd0);
        @(negedge ph1);
        check("idle_hold_addr", 32'(mem_addr), 32'h0040);
        check("idle_mem_we", 32'(mem_we), 32'd0);
        tick();
        check("idle_rvalid", 32'(cpu_rvalid), 32'd0);

        // Both requesting, no lock: 4 CPU grants then 1 DMA grant, repeating
        cpu_req  = 1'b1;
        cpu_addr = 16'h0100;
        dma_req  = 1'b1;
        dma_addr = 16'h0200;
        for (int i = 0; i < 10; i++) begin
            exp_d = ((i % 5) == 4);
            @(negedge ph1);
            check("rr_cpu_gnt", 32'(cpu_gnt), 32'(!exp_d));
            check("rr_dma_gnt", 32'(dma_gnt), 32'(exp_d));
            check("rr_mem_addr", 32'(mem_addr), exp_d ? 32'h0200 : 32'h0100);
            tick();
            check("rr_dma_rvalid", 32'(dma_rvalid), 32'(exp_d));
        end
        idle_all();
        tick();

        // Both requesting with lock: 4 CPU, 8 locked DMA, then CPU again
        cpu_req  = 1'b1;
        dma_req  = 1'b1;
        dma_lock = 1'b1;
        for (int i = 0; i < 14; i++) begin
            exp_d = (i >= 4) && (i <= 11);
            @(negedge ph1);
            check("lk_cpu_gnt", 32'(cpu_gnt), 32'(!exp_d));
            check("lk_dma_gnt", 32'(dma_gnt), 32'(exp_d));
            tick();
        end
        idle_all();
        tick();

        // Write protect: CPU write into ROM is granted but dropped
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = 16'hF000;
        cpu_wdata = 8'hAA;
        @(negedge ph1);
        check("wp_cpu_gnt", 32'(cpu_gnt), 32'd1);
        check("wp_mem_we", 32'(mem_we), 32'd0);
        tick();
        idle_all();
        check("wp_err_pulse", 32'(wp_err), 32'd1);
        tick();
        check("wp_err_clear", 32'(wp_err), 32'd0);
        check("wp_rom_kept", 32'(mem[16'hF000]), 32'h5A);

        // Boundary: EFFF is RAM, FFFF is ROM
        dma_req   = 1'b1;
        dma_we    = 1'b1;
        dma_addr  = 16'hEFFF;
        dma_wdata = 8'h11;
        @(negedge ph1);
        check("efff_dma_gnt", 32'(dma_gnt), 32'd1);
        check("efff_mem_we", 32'(mem_we), 32'd1);
        tick();
        check("efff_wp_err", 32'(wp_err), 32'd0);
        check("efff_written", 32'(mem[16'hEFFF]), 32'h11);
        dma_addr = 16'hFFFF;
        @(negedge ph1);
        check("ffff_mem_we", 32'(mem_we), 32'd0);
        tick();
        idle_all();
        check("ffff_wp_err", 32'(wp_err), 32'd1);
        tick();

        // Reset mid-burst (LOCK, burst 3): returns to FREE with everything cleared
        dma_req  = 1'b1;
        dma_lock = 1'b1;
        dma_addr = 16'h0300;
        for (int i = 0; i < 3; i++) begin
            @(negedge ph1);
            check("mb_dma_gnt", 32'(dma_gnt), 32'd1);
            tick();
        end
        check("mb_dma_rvalid", 32'(dma_rvalid), 32'd1);
        reset    = 1'b1;
        cpu_req  = 1'b1;
        cpu_addr = 16'h0100;
        @(negedge ph1);
        check("mbr_dma_gnt", 32'(dma_gnt), 32'd0);
        check("mbr_cpu_gnt", 32'(cpu_gnt), 32'd0);
        tick();
        check("mbr_dma_rvalid", 32'(dma_rvalid), 32'd0);
        check("mbr_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
        check("mbr_stat_cpu", 32'(stat_cpu), 32'd0);
        check("mbr_stat_dma", 32'(stat_dma), 32'd0);
        reset = 1'b0;
        @(negedge ph1);
        check("mbr_free_cpu_gnt", 32'(cpu_gnt), 32'd1);
        check("mbr_free_dma_gnt", 32'(dma_gnt), 32'd0);
        tick();
        idle_all();

        // Statistics: 10 CPU-only grants from a clean reset
        reset = 1'b1;
        tick();
        reset    = 1'b0;
        cpu_req  = 1'b1;
        cpu_addr = 16'h0050;
        for (int i = 0; i < 10; i++) tick();
        idle_all();
        tick();
`ifdef MEM_ARB_STATS_EN
        check("stat_cpu", 32'(stat_cpu), 32'd10);
`else
        check("stat_cpu", 32'(stat_cpu), 32'd0);
`endif
        check("stat_dma", 32'(stat_dma), 32'd0);
        check("stat_stall", 32'(stat_stall), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
